// File: rtl/controle_jogo.sv
// rtl/controle_jogo.sv - game-flow controller: round sequencing, pause, win/loss, kill score and high score
module controle_jogo #(
    parameter int N_INIMIGOS     = 20,
    parameter int KEY_START      = 3,
    parameter int RESTART_CYCLES = 4,
    parameter int HOLD_CYCLES    = 25000000,
    parameter int PTS_POR_ABATE  = 10,
    parameter int PTS_MAX        = 9990
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic [3:0]            keysout,
    input  logic                  perdeu,
    input  logic [N_INIMIGOS-1:0] inimigo_vivo_array,
    output logic                  pausa,
    output logic                  reiniciarJogo,
    output logic [2:0]            estado,
    output logic [13:0]           pontos,
    output logic [13:0]           recorde,
    output logic [4:0]            abates,
    output logic                  fim_jogo
);

    typedef enum logic [2:0] {
        ESPERA      = 3'd0,
        JOGANDO     = 3'd1,
        PAUSADO     = 3'd2,
        VITORIA     = 3'd3,
        DERROTA     = 3'd4,
        REINICIANDO = 3'd5
    } estado_t;

    localparam int RW = (RESTART_CYCLES > 1) ? $clog2(RESTART_CYCLES) : 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [RW-1:0] RST_LAST  = RW'(RESTART_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [15:0]   PTS16     = 16'(PTS_POR_ABATE);
    localparam logic [15:0]   PMAX16    = 16'(PTS_MAX);
    localparam logic [5:0]    NMAX6     = 6'(N_INIMIGOS);

    estado_t                 estado_q, estado_d;
    logic [RW-1:0]           rst_cnt_q, rst_cnt_d;
    logic [HW-1:0]           hold_q, hold_d;
    logic [13:0]             pontos_q, pontos_d;
    logic [13:0]             recorde_q, recorde_d;
    logic [4:0]              abates_q, abates_d;
    logic                    pausa_q, reinic_q, fim_q;
    logic                    k_q;
    logic [N_INIMIGOS-1:0]   vivo_q;
    logic [N_INIMIGOS-1:0]   mortos;
    logic [5:0]              kills;
    logic [15:0]             soma_pts;
    logic [5:0]              soma_ab;
    logic                    start_ev;
    logic                    unused_ok;

    assign start_ev  = keysout[KEY_START] & ~k_q;
    assign mortos    = vivo_q & ~inimigo_vivo_array;
    assign soma_pts  = {2'b00, pontos_q} + {10'b0, kills} * PTS16;
    assign soma_ab   = {1'b0, abates_q} + kills;
    assign unused_ok = ^{keysout, soma_pts[15:14], soma_ab[5]};

    always_comb begin
        kills = 6'd0;
        for (int i = 0; i < N_INIMIGOS; i++) begin
            kills = kills + 6'(mortos[i]);
        end
    end

    always_comb begin
        estado_d  = estado_q;
        rst_cnt_d = rst_cnt_q;
        hold_d    = hold_q;
        pontos_d  = pontos_q;
        abates_d  = abates_q;
        recorde_d = recorde_q;
        case (estado_q)
            ESPERA: begin
                if (start_ev) estado_d = REINICIANDO;
            end
            REINICIANDO: begin
                if (rst_cnt_q == RST_LAST) estado_d = JOGANDO;
                else rst_cnt_d = rst_cnt_q + 1'b1;
            end
            JOGANDO: begin
                // kills on the exit edge still count toward the final score
                pontos_d = (soma_pts > PMAX16) ? PMAX16[13:0] : soma_pts[13:0];
                abates_d = (soma_ab > NMAX6) ? NMAX6[4:0] : soma_ab[4:0];
                if (perdeu) estado_d = DERROTA;
                else if (inimigo_vivo_array == '0) estado_d = VITORIA;
                else if (start_ev) estado_d = PAUSADO;
            end
            PAUSADO: begin
                if (start_ev) estado_d = JOGANDO;
            end
            VITORIA, DERROTA: begin
                if (hold_q == HOLD_LAST) begin
                    if (start_ev) estado_d = REINICIANDO;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: estado_d = ESPERA;
        endcase

        if (estado_d == REINICIANDO && estado_q != REINICIANDO) begin
            pontos_d  = '0;
            abates_d  = '0;
            rst_cnt_d = '0;
        end
        if ((estado_d == VITORIA || estado_d == DERROTA) && estado_q == JOGANDO) begin
            hold_d = '0;
            if (pontos_d > recorde_q) recorde_d = pontos_d;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        vivo_q <= inimigo_vivo_array;
        if (reset) begin
            estado_q  <= ESPERA;
            rst_cnt_q <= '0;
            hold_q    <= '0;
            pontos_q  <= '0;
            recorde_q <= '0;
            abates_q  <= '0;
            pausa_q   <= 1'b1;
            reinic_q  <= 1'b0;
            fim_q     <= 1'b0;
            k_q       <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            rst_cnt_q <= rst_cnt_d;
            hold_q    <= hold_d;
            pontos_q  <= pontos_d;
            recorde_q <= recorde_d;
            abates_q  <= abates_d;
            pausa_q   <= (estado_d != JOGANDO);
            reinic_q  <= (estado_d == REINICIANDO);
            fim_q     <= (estado_d == VITORIA) || (estado_d == DERROTA);
            k_q       <= keysout[KEY_START];
        end
    end

    assign estado        = estado_q;
    assign pausa         = pausa_q;
    assign reiniciarJogo = reinic_q;
    assign pontos        = pontos_q;
    assign recorde       = recorde_q;
    assign abates        = abates_q;
    assign fim_jogo      = fim_q;

endmodule
